// File: rtl/smart_home_display_decoder.sv
// Front-panel annunciator: filters the controller's display code, decodes it to 7 segments.
// Optional alarm-class blinking is enabled by defining DISP_BLINK_EN.
module smart_home_display_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned BLINK_HALF    = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [2:0]       display,
  input  logic             ack,
  output logic [6:0]       seg,
  output logic [2:0]       shown_code,
  output logic             new_event,
  output logic             alarm_latch,
  output logic [CNT_W-1:0] event_cnt
);

  typedef enum logic {STABLE, PENDING} filt_state_e;

  localparam int unsigned   CW        = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [2:0]    CODE_IDLE = 3'b000;
  localparam logic [2:0]    CODE_FIRE = 3'b011;
  localparam logic [2:0]    CODE_WIN  = 3'b100;

  filt_state_e      state_q, state_d;
  logic [2:0]       sample_q;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       shown_q, shown_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             commit;
  logic             new_event_q, new_event_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic             blink_off;

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q     <= STABLE;
      sample_q    <= CODE_IDLE;
      cand_q      <= CODE_IDLE;
      shown_q     <= CODE_IDLE;
      cnt_q       <= '0;
      new_event_q <= 1'b0;
      alarm_q     <= 1'b0;
      evt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= display;
      cand_q      <= cand_d;
      shown_q     <= shown_d;
      cnt_q       <= cnt_d;
      new_event_q <= new_event_d;
      alarm_q     <= alarm_d;
      evt_q       <= evt_d;
    end
  end

  // Returning to the shown code abandons the candidate before any other check.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      STABLE: begin
        if (sample_q != shown_q) begin
          cand_d  = sample_q;
          cnt_d   = '0;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (sample_q == shown_q) begin
          state_d = STABLE;
        end else if (sample_q != cand_q) begin
          cand_d = sample_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  // Commit side effects; a fire-alarm commit beats a coincident ack.
  always_comb begin
    shown_d     = commit ? cand_q : shown_q;
    new_event_d = commit && (cand_q != CODE_IDLE);
    evt_d       = evt_q;
    if (new_event_d && (evt_q != {CNT_W{1'b1}})) begin
      evt_d = evt_q + 1'b1;
    end
    alarm_d = alarm_q;
    if (commit && (cand_q == CODE_FIRE)) begin
      alarm_d = 1'b1;
    end else if (ack && (shown_q != CODE_FIRE)) begin
      alarm_d = 1'b0;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned   BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (!Rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (commit) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  assign blink_off = ~phase_q;
`else
  // BLINK_HALF has no effect when blinking is compiled out.
  logic [31:0] unused_blink_half;
  assign unused_blink_half = BLINK_HALF;
  assign blink_off         = 1'b0;
`endif

  always_comb begin
    case (shown_q)
      3'b000:  seg = 7'h40;
      3'b001:  seg = 7'h71;
      3'b010:  seg = 7'h50;
      3'b011:  seg = 7'h77;
      3'b100:  seg = 7'h1C;
      3'b101:  seg = 7'h76;
      3'b110:  seg = 7'h39;
      default: seg = 7'h79;
    endcase
    if (blink_off && ((shown_q == CODE_FIRE) || (shown_q == CODE_WIN))) begin
      seg = 7'h00;
    end
  end

  assign shown_code  = shown_q;
  assign new_event   = new_event_q;
  assign alarm_latch = alarm_q;
  assign event_cnt   = evt_q;

endmodule

// File: tb/tb_smart_home_display_decoder.sv
// Randomized self-checking bench for smart_home_display_decoder against a run-length reference model.
// Honours DISP_BLINK_EN the same way the design does.
module tb_smart_home_display_decoder;

  localparam int SC = 4;
  localparam int BH = 8;
  localparam int CW = 2;

  logic          clk;
  logic          Rst;
  logic [2:0]    display;
  logic          ack;
  logic [6:0]    seg;
  logic [2:0]    shown_code;
  logic          new_event;
  logic          alarm_latch;
  logic [CW-1:0] event_cnt;

  smart_home_display_decoder #(
    .STABLE_CYCLES(SC),
    .BLINK_HALF   (BH),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .Rst        (Rst),
    .display    (display),
    .ack        (ack),
    .seg        (seg),
    .shown_code (shown_code),
    .new_event  (new_event),
    .alarm_latch(alarm_latch),
    .event_cnt  (event_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int numChecks = 0;
  int numFails  = 0;

  logic [6:0] segTable [8] = '{7'h40, 7'h71, 7'h50, 7'h77, 7'h1C, 7'h76, 7'h39, 7'h79};

  // Reference state: the code last sampled, the code shown, and the length of the
  // current run of identical non-shown samples seen by the filter.
  int mSample = 0;
  int mShown  = 0;
  int mRunVal = 0;
  int mRun    = 0;
  int mNew    = 0;
  int mAlarm  = 0;
  int mCnt    = 0;
  int mSince  = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numChecks++;
    if (observed != expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input int d, input int a, input int r);
    int commit;
    int newE;
    if (r == 0) begin
      mSample = 0; mShown = 0; mRunVal = 0; mRun = 0;
      mNew = 0; mAlarm = 0; mCnt = 0; mSince = 0;
    end else begin
      commit = 0;
      if (mSample == mShown) begin
        mRun = 0;
      end else begin
        if (mRun > 0 && mSample == mRunVal) mRun++;
        else begin
          mRunVal = mSample;
          mRun    = 1;
        end
        if (mRun == SC + 1) begin
          commit = 1;
          mRun   = 0;
        end
      end
      newE = (commit != 0 && mRunVal != 0) ? 1 : 0;
      if (commit != 0 && mRunVal == 3) mAlarm = 1;
      else if (a != 0 && mShown != 3) mAlarm = 0;
      if (newE != 0 && mCnt < (1 << CW) - 1) mCnt++;
      mSince  = (commit != 0) ? 0 : mSince + 1;
      if (commit != 0) mShown = mRunVal;
      mNew    = newE;
      mSample = d;
    end
  endtask

  function automatic int expectedSeg();
    int s;
    s = segTable[mShown];
`ifdef DISP_BLINK_EN
    if (((mSince / BH) % 2) != 0 && (mShown == 3 || mShown == 4)) s = 0;
`endif
    return s;
  endfunction

  // One clock: drive on the falling edge, advance the model, compare just after the rising edge.
  task automatic applyStimulus(input logic [2:0] d, input logic a, input logic r);
    @(negedge clk);
    display = d;
    ack     = a;
    Rst     = r;
    @(posedge clk);
    modelStep(int'(d), int'(a), int'(r));
    #1;
    checkOutput("seg",         int'(seg),         expectedSeg());
    checkOutput("shown_code",  int'(shown_code),  mShown);
    checkOutput("new_event",   int'(new_event),   mNew);
    checkOutput("alarm_latch", int'(alarm_latch), mAlarm);
    checkOutput("event_cnt",   int'(event_cnt),   mCnt);
  endtask

  task automatic holdCode(input logic [2:0] d, input int n);
    for (int i = 0; i < n; i++) applyStimulus(d, 1'b0, 1'b1);
  endtask

  initial begin
    display = 3'b000;
    ack     = 1'b0;
    Rst     = 1'b0;

    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("reset_seg", int'(seg), 'h40);

    // Latency: committed on the sixth edge, not the fifth.
    holdCode(3'b001, 5);
    checkOutput("lat_before", int'(shown_code), 0);
    applyStimulus(3'b001, 1'b0, 1'b1);
    checkOutput("lat_shown", int'(shown_code), 1);
    checkOutput("lat_pulse", int'(new_event), 1);
    holdCode(3'b001, 3);
    holdCode(3'b000, 8);

    // Glitch of exactly STABLE_CYCLES samples must be rejected.
    holdCode(3'b011, SC);
    holdCode(3'b000, 8);
    checkOutput("glitch_alarm", int'(alarm_latch), 0);

    // Fire alarm, ack ignored while shown, then cleared after idle.
    holdCode(3'b011, 8);
    applyStimulus(3'b011, 1'b1, 1'b1);
    applyStimulus(3'b011, 1'b1, 1'b1);
    checkOutput("alarm_held", int'(alarm_latch), 1);
    holdCode(3'b000, 8);
    applyStimulus(3'b000, 1'b1, 1'b1);
    checkOutput("alarm_clear", int'(alarm_latch), 0);

    // Window code held long enough to see several blink phases.
    holdCode(3'b100, 40);

    // Alternating accepted codes saturate the narrow counter.
    for (int k = 0; k < 5; k++) begin
      holdCode(3'b101, 7);
      holdCode(3'b110, 7);
    end
    checkOutput("sat_cnt", int'(event_cnt), 3);
    holdCode(3'b111, 8);
    checkOutput("invalid_seg", int'(seg), 'h79);

    // Reset while 010 is pending.
    holdCode(3'b010, 4);
    applyStimulus(3'b010, 1'b0, 1'b0);
    checkOutput("rst_pend_cnt", int'(event_cnt), 0);
    holdCode(3'b010, 3);
    checkOutput("rst_pend_shown", int'(shown_code), 0);
    holdCode(3'b010, 4);

    // Random runs of codes with occasional ack and rare resets.
    for (int n = 0; n < 300; n++) begin
      logic [2:0] code;
      int len;
      code = 3'($urandom_range(7, 0));
      if ($urandom_range(3, 0) == 0) code = 3'b011;
      len = $urandom_range(SC + 3, 1);
      for (int i = 0; i < len; i++) begin
        applyStimulus(code, 1'($urandom_range(5, 0) == 0), 1'($urandom_range(99, 0) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
